// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC stage: run-control state encoding,
// default widths and the constant subroutine target table.
package fetch_pc_unit_pkg;

    localparam int PC_W_DEF      = 10;
    localparam int RAS_DEPTH_DEF = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Subroutine entry points selected by jtsr; unlisted indices resolve to 0.
    function automatic logic [PC_W_DEF-1:0] jsr_target(input logic [3:0] idx);
        logic [PC_W_DEF-1:0] t;
        t = '0;
        case (idx)
            4'd0:    t = 10'd512;
            4'd1:    t = 10'd60;
            4'd2:    t = 10'd128;
            4'd3:    t = 10'd256;
            4'd4:    t = 10'd384;
            4'd5:    t = 10'd1000;
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_ret_stack.sv
// LIFO return-address stack. Push is ignored when full and pop when empty;
// the caller is expected to flag those cases itself.
module ret_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  push_data_i,
    output logic [W-1:0]  top_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] top_ptr;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign top_ptr = cnt_q - CW'(1);
    assign top_o   = mem_q[AW'(top_ptr)];

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= '0;
        end else if (push_i && !full_o) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Entry storage needs no reset: the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!reset && !clear_i && push_i && !full_o) begin
            mem_q[AW'(cnt_q)] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, redirect mux and IDLE/RUN/DONE run control in front of
// instruction memory; subroutine return addresses live in ret_stack.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              RAS_DEPTH = RAS_DEPTH_DEF,
    parameter logic [PC_W-1:0] START_PC  = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           halt,
    input  logic                           stall,
    input  logic                           skip_en,
    input  logic [5:0]                     skip_off,
    input  logic                           jsr_en,
    input  logic [3:0]                     jsr_idx,
    input  logic                           ret_en,
    output logic [PC_W-1:0]                pc,
    output logic                           running,
    output logic                           done,
    output logic                           err,
    output state_t                         dbg_state,
    output logic [$clog2(RAS_DEPTH+1)-1:0] dbg_ras_cnt,
    output logic [PC_W-1:0]                dbg_ras_top
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic            running_q, done_q;

    logic            ras_push, ras_pop, ras_clear;
    logic            ras_empty, ras_full;
    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] skip_sext;

    assign pc_seq    = pc_q + PC_W'(1);
    assign skip_sext = {{(PC_W-6){skip_off[5]}}, skip_off};

    ret_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ret_stack (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (ras_clear),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_seq),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full),
        .count_o     (dbg_ras_cnt)
    );

    // Control inputs are evaluated in strict priority; only one stack op per cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        err_d     = err_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    pc_d      = START_PC;
                    err_d     = 1'b0;
                    ras_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (stall) begin
                    state_d = state_q;
                end else if (halt) begin
                    state_d = ST_DONE;
                end else if (ret_en) begin
                    if (ras_empty) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        pc_d    = ras_top;
                        ras_pop = 1'b1;
                    end
                end else if (jsr_en) begin
                    if (ras_full) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        pc_d     = PC_W'(jsr_target(jsr_idx));
                        ras_push = 1'b1;
                    end
                end else if (skip_en) begin
                    pc_d = pc_seq + skip_sext;
                end else begin
                    pc_d = pc_seq;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign pc          = pc_q;
    assign running     = running_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state   = state_q;
    assign dbg_ras_top = ras_top;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-sequencing stage directly upstream of the instruction memory of the 9-bit CPU. Holds the 10-bit `pc` that addresses instruction memory, advances it each cycle, and applies relative skips, table-based subroutine calls (`jtsr`) and returns (`rfsr`) as directed by the decoder. Includes a small return-address stack and a start/halt run-control state machine.

## Interface
- `PC_W`, 10, program-counter width (instruction memory depth = 2^PC_W)
- `RAS_DEPTH`, 4, return-address stack entries
- `START_PC`, 0, pc loaded on `start`
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `start`  in  1  pulse: begin execution at `START_PC`
- `halt`  in  1  decoder saw halt instruction; stop after this cycle
- `stall`  in  1  hold pc and all state this cycle
- `skip_en`  in  1  taken relative branch (`jizr`/`bnzr`)
- `skip_off`  in  6  signed offset, two's complement
- `jsr_en`  in  1  subroutine call (`jtsr`)
- `jsr_idx`  in  4  subroutine index
- `ret_en`  in  1  subroutine return (`rfsr`)
- `pc`  out  PC_W  current instruction address
- `running`  out  1  high in RUN state
- `done`  out  1  high in DONE state
- `err`  out  1  sticky: stack overflow/underflow

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, `pc`=0, stack empty, `running`=0, `done`=0, `err`=0.
- IDLE: `pc` held. `start` → RUN, `pc`<=`START_PC`, stack cleared, `err` cleared.
- RUN, priority per cycle (highest first): `stall`, `halt`, `ret_en`, `jsr_en`, `skip_en`, sequential.
  - `stall`: nothing changes (control inputs ignored).
  - `halt` → DONE, `pc` held.
  - `ret_en`: stack empty → `err`<=1, → DONE; else `pc`<=top, pop.
  - `jsr_en`: stack full → `err`<=1, → DONE; else push `pc+1`, `pc`<=`lut[jsr_idx]`.
  - `skip_en`: `pc`<=`pc + 1 + sext(skip_off)`; `skip_off`=1 skips exactly one instruction.
  - else `pc`<=`pc+1`.
- All pc arithmetic modulo 2^PC_W (1023+1 → 0; 0+1+(-2) → 1023).
- DONE: `pc` held, `done`=1; `start` re-enters RUN as from IDLE.
- `start` ignored in RUN.
- Subroutine table: 16 entries of PC_W bits, constants; unused entries = 0.
- Stack is LIFO, depth `RAS_DEPTH`; push and pop never in same cycle (priority excludes).

## Timing
- `pc` is a register; instruction memory is combinational, so the instruction at `pc` is valid the same cycle and the decoder drives control inputs combinationally in that cycle.
- Any redirect takes effect on the next edge: one-cycle latency, no delay slot, no bubble.
- `running`/`done` are registered state decodes, updated with the state edge.
- `reset` asserted at any time (including mid-call with non-empty stack or during stall) returns everything to reset values on that edge; overrides `start`.

## Structure
- Shared package: state enum (IDLE/RUN/DONE), `PC_W` default, 16-entry subroutine target constant array, `RAS_DEPTH` default.
- One sub-module: `ret_stack` (push/pop/top/empty/full, synchronous reset); pc mux and FSM stay in the top.

## Test plan
- Reset then `start` with no controls for 5 cycles → pc 0,1,2,3,4,5; `running`=1; `done`=0.
- At pc=20 `skip_en`, `skip_off`=1 → pc=22; at pc=22 `skip_off`=-8 → pc=15; at pc=1023 no control → pc=0.
- lut[1]=60: at pc=19 `jsr_en` idx 1 → pc=60, top=20; then `ret_en` → pc=20, stack empty.
- Five nested `jsr_en` with `RAS_DEPTH`=4 → fifth sets `err`=1, enters DONE, pc holds; `ret_en` on empty stack likewise → `err`=1, DONE.
- `stall` with `jsr_en` and `halt` at pc=7 → pc stays 7, stack unchanged; next cycle `halt` alone → DONE, `done`=1, pc=7; `start` → pc=0, `err`=0.
- `reset` asserted in RUN with 2 stacked returns → next cycle IDLE, pc=0, stack empty, all outputs 0.
